pipelined_control_unit: RTL
===========================

Name: pipelined_control_unit

Overview:
- Next-generation RISC-V decode-stage control block: decodes InstrD and registers all control into the E stage through an internal ID/EX control register with stall, flush and valid tracking.
- Adds optional RV32M decode under parameter, and a multi-cycle MUL/DIV occupancy sequencer that holds E and stalls upstream.
- Adds illegal-instruction detection and an unsigned-load flag.
- Sits between the D-stage instruction register and the E-stage datapath, alongside the hazard unit.

Parameters:
- ENABLE_M, 1, 1 = decode RV32M; 0 = RV32M encodings flagged illegal.
- MUL_CYCLES, 2, E-stage occupancy (cycles) for MUL/MULH/MULHSU/MULHU; legal range 1..255.
- DIV_CYCLES, 33, E-stage occupancy for DIV/DIVU/REM/REMU; legal range 1..255.
- ALU_CTRL_W, 5, ALUControlE width; must be ≥5 when ENABLE_M=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- InstrD  in  32  D-stage instruction.
- ValidD  in  1  InstrD holds a real instruction.
- StallE  in  1  hazard-unit hold of the E register.
- FlushE  in  1  bubble into E at next edge.
- RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, UsePCEforAE, isJalrE  out  1 each  registered controls.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  ALU_CTRL_W  ALU operation code.
- ImmSrcE  out  3  immediate format.
- MemSizeE  out  2  00 byte, 01 half, 10 word.
- MemUnsignedE  out  1  LBU/LHU.
- ValidE  out  1  E holds a real instruction.
- IllegalE  out  1  E instruction is illegal.
- MdStallD  out  1  multi-cycle op occupying E; stall F/D.
- MdDoneE  out  1  final E cycle of a MUL/DIV op.

Behaviour:
- Reset, priority over everything:
  - Every registered output is 0; sequencer returns to IDLE with counter 0.
  - Applies in the same edge even mid-operation.
- Decode is combinational on InstrD. The existing RV32I control encodings are unchanged; ALU codes 0x00–0x0F are preserved.
- M ops (opcode 0110011, funct7 0000001, ENABLE_M=1):
  - ALUControl = 0x10 + funct3 (MUL 0x10 … REMU 0x17).
  - RegWrite=1, ResultSrc=00.
- Illegal conditions:
  - unknown opcode;
  - load funct3 ∈ {011,110,111};
  - store funct3 > 010;
  - branch funct3 ∈ {010,011};
  - OP funct7 not in {0000000, 0100000(ADD/SUB, SRL/SRA only), 0000001 when ENABLE_M};
  - ENABLE_M=0 with funct7 0000001.
  - Response: IllegalE=1, all write/branch/jump enables 0. ValidE still follows ValidD.
- ValidD=0: the same as a bubble.
- E register update, per edge, in priority order:
  1. reset;
  2. hold (StallE or MdStallD): keep contents;
  3. FlushE: load bubble (ValidE=0, all enables 0, IllegalE=0);
  4. otherwise load decoded values. ValidE=ValidD.
  - FlushE during hold is ignored.
- Sequencer states: IDLE, BUSY. 8-bit down-counter.
- Start: only on an edge where the E register loads a new valid, legal M op with latency LAT > 1.
  - Go to BUSY with cnt=LAT-1.
  - LAT=1 never enters BUSY.
- BUSY:
  - cnt decrements every cycle regardless of StallE.
  - When cnt==1, the next state is IDLE.
  - BUSY therefore lasts LAT-1 cycles and E occupancy is LAT cycles.
- MdStallD is 1 exactly while in BUSY.
- MdDoneE = ValidE & (E holds M op) & !MdStallD & !started-done flag.
  - Pulses once, on the last occupancy cycle.
  - Does not re-pulse if StallE later keeps the op in E.
- No restart while the same op is held by StallE in IDLE.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants;
  - ALU control codes including M codes 0x10–0x17;
  - ImmSrc, ResultSrc and MemSize encodings;
  - sequencer state enum (IDLE/BUSY).
- Combinational decode reuses the existing main and ALU decoder logic, extended for M ops and the illegal/unsigned flags.
- One sub-module, md_sequencer, contains the counter, state and done flag. Its inputs are start and latency; its outputs are busy and done.

Test Plan:
1. ADD 0x002081B3, ValidD=1 → next edge: RegWriteE=1, ALUControlE=ADD code, ResultSrcE=00, ValidE=1, IllegalE=0, MdStallD=0.
2. LHU 0x00015083 → MemSizeE=01, MemUnsignedE=1, ResultSrcE=01, ALUSrcE=1, MemWriteE=0.
3. MUL 0x027302B3, MUL_CYCLES=2 → ALUControlE=0x10.
   - MdStallD=1 for exactly 1 cycle after capture; E held.
   - MdDoneE=1 in the following cycle only.
   - The next InstrD is loaded the edge after.
4. DIVU 0x0272D2B3, DIV_CYCLES=33 → MdStallD high for exactly 32 cycles. Repeat with reset asserted at stall cycle 10 → next edge: all outputs 0, MdStallD=0.
5. ENABLE_M=0, MUL 0x027302B3 → IllegalE=1, RegWriteE=0, MdStallD stays 0. Opcode 0x0000007F → IllegalE=1.
6. StallE=1 with FlushE=1 → E contents unchanged. FlushE=1 alone → ValidE=0 and all enables 0 next edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RISC-V decode-stage control unit: opcodes, ALU codes,
// control field enums, the ID/EX control record and the MUL/DIV sequencer states.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [4:0] ALU_ADD  = 5'h00;
  localparam logic [4:0] ALU_SUB  = 5'h01;
  localparam logic [4:0] ALU_AND  = 5'h02;
  localparam logic [4:0] ALU_OR   = 5'h03;
  localparam logic [4:0] ALU_XOR  = 5'h04;
  localparam logic [4:0] ALU_SLT  = 5'h05;
  localparam logic [4:0] ALU_SLTU = 5'h06;
  localparam logic [4:0] ALU_SLL  = 5'h07;
  localparam logic [4:0] ALU_SRL  = 5'h08;
  localparam logic [4:0] ALU_SRA  = 5'h09;
  localparam logic [4:0] ALU_LUI  = 5'h0A;
  // M codes are ALU_MUL + funct3, so MUL..REMU occupy 0x10..0x17.
  localparam logic [4:0] ALU_MUL  = 5'h10;
  localparam logic [4:0] ALU_REMU = 5'h17;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_src_e;
  typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} result_src_e;
  typedef enum logic [1:0] {MEM_B = 2'b00, MEM_H = 2'b01, MEM_W = 2'b10} mem_size_e;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_e;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic        reg_write;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        use_pc_a;
    logic        is_jalr;
    result_src_e result_src;
    logic [4:0]  alu_ctrl;
    imm_src_e    imm_src;
    mem_size_e   mem_size;
    logic        mem_unsigned;
    logic        is_md;
  } ctrl_t;

  function automatic logic [4:0] alu_base(input logic [2:0] funct3, input logic alt);
    logic [4:0] code;
    case (funct3)
      3'b000:  code = alt ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pipelined_control_unit_md_sequencer.sv
// MUL/DIV E-stage occupancy sequencer: counts down the remaining busy cycles and
// flags the single final-occupancy cycle of a multi-cycle op.
module md_sequencer
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] latency,
  input  logic       load_e,
  input  logic       md_in_e,
  output logic       busy,
  output logic       done
);

  md_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       done_seen_q, done_seen_d;

  assign busy = (state_q == MD_BUSY);
  assign done = md_in_e & ~busy & ~done_seen_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          state_d = MD_BUSY;
          cnt_d   = latency - 8'd1;
        end
      end
      MD_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = MD_IDLE;
      end
    endcase
  end

  // The flag keeps a stalled op from pulsing done twice; any E load clears it.
  always_comb begin
    done_seen_d = done_seen_q | done;
    if (load_e) done_seen_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q     <= MD_IDLE;
      cnt_q       <= 8'd0;
      done_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// RISC-V decode-stage control: decodes InstrD (RV32I + optional RV32M) and registers
// the control word into E with stall, flush, valid and MUL/DIV occupancy handling.
module pipelined_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33,
  parameter int ALU_CTRL_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  ALUSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic                  UsePCEforAE,
  output logic                  isJalrE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            ImmSrcE,
  output logic [1:0]            MemSizeE,
  output logic                  MemUnsignedE,
  output logic                  ValidE,
  output logic                  IllegalE,
  output logic                  MdStallD,
  output logic                  MdDoneE
);

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  ctrl_t      dec, ctrl_d, ctrl_q;
  logic       hold, md_busy, md_done, md_start;
  logic [7:0] md_lat;
  logic       unused_instr;

  assign opcode       = InstrD[6:0];
  assign funct3       = InstrD[14:12];
  assign funct7       = InstrD[31:25];
  assign unused_instr = ^{InstrD[24:15], InstrD[11:7]};

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (opcode)
      OP_LOAD: begin
        dec.reg_write    = 1'b1;
        dec.alu_src      = 1'b1;
        dec.result_src   = RES_MEM;
        dec.imm_src      = IMM_I;
        dec.alu_ctrl     = ALU_ADD;
        dec.mem_unsigned = funct3[2];
        dec.illegal      = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        case (funct3[1:0])
          2'b00:   dec.mem_size = MEM_B;
          2'b01:   dec.mem_size = MEM_H;
          default: dec.mem_size = MEM_W;
        endcase
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_S;
        dec.alu_ctrl  = ALU_ADD;
        dec.illegal   = (funct3 > 3'b010);
        case (funct3[1:0])
          2'b00:   dec.mem_size = MEM_B;
          2'b01:   dec.mem_size = MEM_H;
          default: dec.mem_size = MEM_W;
        endcase
      end
      OP_BRANCH: begin
        dec.branch   = 1'b1;
        dec.imm_src  = IMM_B;
        dec.alu_ctrl = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        dec.illegal  = (funct3[2:1] == 2'b01);
      end
      OP_REG: begin
        dec.reg_write = 1'b1;
        if (funct7 == F7_MULDIV) begin
          dec.alu_ctrl = ALU_MUL | {2'b00, funct3};
          dec.is_md    = 1'b1;
          dec.illegal  = (ENABLE_M == 0);
        end else begin
          dec.alu_ctrl = alu_base(funct3, funct7[5]);
          dec.illegal  = !((funct7 == F7_BASE) ||
                           (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
        end
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_I;
        dec.alu_ctrl  = alu_base(funct3, funct7[5] & (funct3 == 3'b101));
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.use_pc_a   = 1'b1;
        dec.imm_src    = IMM_J;
        dec.result_src = RES_PC4;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.is_jalr    = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm_src    = IMM_I;
        dec.result_src = RES_PC4;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.use_pc_a  = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_ctrl  = ALU_ADD;
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instruction travels as a valid, side-effect-free slot.
    if (dec.illegal) begin
      dec         = '0;
      dec.valid   = 1'b1;
      dec.illegal = 1'b1;
    end
  end

  assign hold     = StallE | md_busy;
  assign md_lat   = funct3[2] ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
  assign md_start = ~hold & ~FlushE & ValidD & dec.is_md & (md_lat > 8'd1);

  always_comb begin
    if (hold)                 ctrl_d = ctrl_q;
    else if (FlushE | ~ValidD) ctrl_d = '0;
    else                      ctrl_d = dec;
  end

  always_ff @(posedge clk) begin
    if (reset) ctrl_q <= '0;
    else       ctrl_q <= ctrl_d;
  end

  md_sequencer u_md_seq (
    .clk     (clk),
    .reset   (reset),
    .start   (md_start),
    .latency (md_lat),
    .load_e  (~hold),
    .md_in_e (ctrl_q.valid & ctrl_q.is_md),
    .busy    (md_busy),
    .done    (md_done)
  );

  assign RegWriteE    = ctrl_q.reg_write;
  assign MemWriteE    = ctrl_q.mem_write;
  assign ALUSrcE      = ctrl_q.alu_src;
  assign BranchE      = ctrl_q.branch;
  assign JumpE        = ctrl_q.jump;
  assign UsePCEforAE  = ctrl_q.use_pc_a;
  assign isJalrE      = ctrl_q.is_jalr;
  assign ResultSrcE   = ctrl_q.result_src;
  assign ALUControlE  = ALU_CTRL_W'(ctrl_q.alu_ctrl);
  assign ImmSrcE      = ctrl_q.imm_src;
  assign MemSizeE     = ctrl_q.mem_size;
  assign MemUnsignedE = ctrl_q.mem_unsigned;
  assign ValidE       = ctrl_q.valid;
  assign IllegalE     = ctrl_q.illegal;
  assign MdStallD     = md_busy;
  assign MdDoneE      = md_done;

endmodule
